bsg_two_fifo_async_reset: RTL and testbench



---
 rtl/bsg_two_fifo_async_reset_pkg.sv | 12 +
 rtl/bsg_two_fifo_async_reset_if.sv | 30 +++
 rtl/bsg_two_fifo_async_reset_dff.sv | 17 +
 rtl/bsg_two_fifo_async_reset.sv | 84 ++++++++
 tb/tb_bsg_two_fifo_async_reset.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/bsg_two_fifo_async_reset_pkg.sv
// Shared types and constants for the two-entry ready/valid buffer.
package bsg_two_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } bsg_two_fifo_state_e;

    localparam int unsigned bsg_two_fifo_els_gp = 2;

endpackage

// File: rtl/bsg_two_fifo_async_reset_if.sv
// Producer/consumer handshake bundle for bsg_two_fifo_async_reset.
// The slave modport is the buffer side; the master modport is the environment side.
interface bsg_two_fifo_async_reset_if #(
    parameter int unsigned width_p = 32
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport slave (
        input  v_i,
        input  data_i,
        output ready_o,
        output v_o,
        output data_o,
        input  yumi_i
    );

    modport master (
        output v_i,
        output data_i,
        input  ready_o,
        input  v_o,
        input  data_o,
        output yumi_i
    );
endinterface

// File: rtl/bsg_two_fifo_async_reset_dff.sv
// Enable-gated register with asynchronous active-high reset to zero.
module bsg_dff_async_reset_en #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            data_o <= '0;
        else if (en_i)
            data_o <= data_i;
    end
endmodule

// File: rtl/bsg_two_fifo_async_reset.sv
// Two-entry ready/valid buffer with registered ready and no bypass path.
// Optional simulation checks: define BSG_TWO_FIFO_ASYNC_RESET_ASSERT_EN.
module bsg_two_fifo_async_reset
    import bsg_two_fifo_pkg::*;
#(
    parameter int unsigned width_p = 32
) (
    input logic                              clk_i,
    input logic                              reset_i,
    bsg_two_fifo_async_reset_if.slave        fifo
);
    bsg_two_fifo_state_e state_r, state_n;
    logic               wr_ptr, rd_ptr;
    logic               ready_r;
    logic               enq, deq;
    logic [width_p-1:0] entry [bsg_two_fifo_els_gp];

    assign enq = fifo.v_i & ready_r;
    // A yumi while empty is a protocol error; it must not move the read pointer.
    assign deq = fifo.yumi_i & (state_r != EMPTY);

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            EMPTY:   if (enq) state_n = ONE;
            ONE: begin
                if (enq & ~deq)      state_n = FULL;
                else if (deq & ~enq) state_n = EMPTY;
            end
            FULL:    if (deq) state_n = ONE;
            default: state_n = EMPTY;
        endcase
    end

    // ready is its own flop so it stays low through reset and rises one edge later.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= EMPTY;
            ready_r <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            state_r <= state_n;
            ready_r <= (state_n != FULL);
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
        end
    end

    for (genvar i = 0; i < bsg_two_fifo_els_gp; i++) begin : g_entry
        bsg_dff_async_reset_en #(.width_p(width_p)) u_entry (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (enq & (wr_ptr == 1'(i))),
            .data_i  (fifo.data_i),
            .data_o  (entry[i])
        );
    end

    assign fifo.ready_o = ready_r;
    assign fifo.v_o     = (state_r != EMPTY);
    assign fifo.data_o  = entry[rd_ptr];

`ifdef BSG_TWO_FIFO_ASYNC_RESET_ASSERT_EN
    int unsigned cycle_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cycle_q <= 0;
        else         cycle_q <= cycle_q + 1;
    end

    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
        fifo.yumi_i |-> fifo.v_o)
        else $error("yumi_i asserted while v_o=0 at cycle %0d", cycle_q);

    a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_r == FULL) |-> !enq)
        else $error("enq while FULL at cycle %0d", cycle_q);

    a_occupancy: assert property (@(posedge clk_i) disable iff (reset_i)
        state_r inside {EMPTY, ONE, FULL})
        else $error("occupancy state_r exceeds 2 at cycle %0d", cycle_q);
`endif

endmodule

// File: tb/tb_bsg_two_fifo_async_reset.sv
// Directed self-checking bench for bsg_two_fifo_async_reset.
module tb_bsg_two_fifo_async_reset;
    logic clk;
    logic reset_i;
    int   compared;
    int   mismatched;

    bsg_two_fifo_async_reset_if #(.width_p(32)) bus ();

    bsg_two_fifo_async_reset #(.width_p(32)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .fifo    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_i     = 1'b1;
        bus.v_i     = 1'b1;
        bus.data_i  = 32'hFFFF_FFFF;
        bus.yumi_i  = 1'b0;

        // reset held 3 cycles with v_i asserted
        repeat (3) step();
        chk("rst_v_o",     32'(bus.v_o),     32'd0);
        chk("rst_ready_o", 32'(bus.ready_o), 32'd0);
        chk("rst_data_o",  bus.data_o,       32'd0);
        reset_i = 1'b0;
        #1;
        chk("rel_ready_still0", 32'(bus.ready_o), 32'd0);
        step();
        chk("rel_ready_o", 32'(bus.ready_o), 32'd1);
        chk("rel_no_enq",  32'(bus.v_o),     32'd0);

        // single transfer
        bus.v_i = 1'b1; bus.data_i = 32'hDEAD_BEEF;
        step();
        bus.v_i = 1'b0;
        chk("single_v_o",   32'(bus.v_o),     32'd1);
        chk("single_data",  bus.data_o,       32'hDEAD_BEEF);
        chk("single_ready", 32'(bus.ready_o), 32'd1);
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        chk("single_pop_v_o",  32'(bus.v_o),     32'd0);
        chk("single_pop_ready", 32'(bus.ready_o), 32'd1);

        // fill, overflow attempt, drain
        bus.v_i = 1'b1; bus.data_i = 32'h1;
        step();
        chk("fill1_v_o",   32'(bus.v_o),     32'd1);
        chk("fill1_data",  bus.data_o,       32'h1);
        chk("fill1_ready", 32'(bus.ready_o), 32'd1);
        bus.data_i = 32'h2;
        step();
        chk("fill2_ready", 32'(bus.ready_o), 32'd0);
        chk("fill2_data",  bus.data_o,       32'h1);
        bus.data_i = 32'h3;
        step();
        chk("ovf_ready", 32'(bus.ready_o), 32'd0);
        chk("ovf_data",  bus.data_o,       32'h1);
        bus.v_i = 1'b0; bus.yumi_i = 1'b1;
        step();
        chk("drain1_v_o",   32'(bus.v_o),     32'd1);
        chk("drain1_data",  bus.data_o,       32'h2);
        chk("drain1_ready", 32'(bus.ready_o), 32'd1);
        step();
        bus.yumi_i = 1'b0;
        chk("drain2_v_o", 32'(bus.v_o), 32'd0);
        step();
        chk("drain_hold_v_o", 32'(bus.v_o), 32'd0);

        // streaming 0..99 from ONE with simultaneous enq/deq
        bus.v_i = 1'b1; bus.data_i = 32'd0;
        step();
        for (int i = 0; i < 100; i++) begin
            chk("stream_v_o",   32'(bus.v_o),     32'd1);
            chk("stream_data",  bus.data_o,       32'(i));
            chk("stream_ready", 32'(bus.ready_o), 32'd1);
            bus.yumi_i = 1'b1;
            bus.v_i    = (i < 99);
            bus.data_i = 32'(i + 1);
            step();
        end
        bus.yumi_i = 1'b0; bus.v_i = 1'b0;
        chk("stream_end_v_o", 32'(bus.v_o), 32'd0);

        // asynchronous reset while FULL
        bus.v_i = 1'b1; bus.data_i = 32'hA;
        step();
        bus.data_i = 32'hB;
        step();
        bus.v_i = 1'b0;
        chk("full_ready", 32'(bus.ready_o), 32'd0);
        chk("full_data",  bus.data_o,       32'hA);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_v_o",   32'(bus.v_o),     32'd0);
        chk("arst_data",  bus.data_o,       32'd0);
        chk("arst_ready", 32'(bus.ready_o), 32'd0);
        #1;
        reset_i = 1'b0;
        step();
        chk("post_arst_v_o",   32'(bus.v_o),     32'd0);
        chk("post_arst_ready", 32'(bus.ready_o), 32'd1);
        bus.v_i = 1'b1; bus.data_i = 32'hC;
        step();
        bus.v_i = 1'b0;
        chk("post_arst_push_data",  bus.data_o,       32'hC);
        chk("post_arst_push_ready", 32'(bus.ready_o), 32'd1);
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        chk("post_arst_pop_v_o", 32'(bus.v_o), 32'd0);

`ifndef BSG_TWO_FIFO_ASYNC_RESET_ASSERT_EN
        // illegal yumi while EMPTY must leave state unchanged
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        chk("illegal_yumi_v_o",   32'(bus.v_o),     32'd0);
        chk("illegal_yumi_ready", 32'(bus.ready_o), 32'd1);
        bus.v_i = 1'b1; bus.data_i = 32'h55;
        step();
        bus.v_i = 1'b0;
        chk("illegal_yumi_next_data", bus.data_o, 32'h55);
        bus.data_i = 32'h66; bus.v_i = 1'b1;
        step();
        bus.v_i = 1'b0;
        chk("illegal_yumi_order_ready", 32'(bus.ready_o), 32'd0);
        chk("illegal_yumi_order_head",  bus.data_o,       32'h55);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
